// File: rtl/validator_if.sv
// Validator bus: the new-move controller command/result signals and the
// synchronous-read board memory port, grouped so the walker has one port.
//   enable/ld/step_in/pos_in/player_in : command from the controller
//   s_done_o/dir_status_o/count_o       : walk result back to the controller
//   mem_addr_o/mem_data_i               : board memory read port
// slave  = the validator side, master = the controller/memory side.
interface validator_if;
  logic       enable;
  logic       ld;
  logic [4:0] step_in;
  logic [6:0] pos_in;
  logic       player_in;
  logic [6:0] mem_addr_o;
  logic [1:0] mem_data_i;
  logic       s_done_o;
  logic       dir_status_o;
  logic [2:0] count_o;

  modport slave (
    input  enable, ld, step_in, pos_in, player_in, mem_data_i,
    output mem_addr_o, s_done_o, dir_status_o, count_o
  );

  modport master (
    output enable, ld, step_in, pos_in, player_in, mem_data_i,
    input  mem_addr_o, s_done_o, dir_status_o, count_o
  );
endinterface

// File: rtl/validator.sv
// Direction validator: walks from a candidate move along one direction,
// counting opponent discs until it meets an own disc (bracketed), an empty
// or border cell, an off-board address, or the run limit.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous active-low reset
//   bus    - validator_if.slave (command, result and board memory port)
// Parameters:
//   BOARD_CELLS - addressable cells; addresses at or above act as border
//   MAX_RUN     - opponent cells walked before the walk is forced to end
module validator #(
  parameter int unsigned BOARD_CELLS = 100,
  parameter int unsigned MAX_RUN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  validator_if.slave bus
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned STEP_W = 5;
  localparam int unsigned CNT_W  = $clog2(MAX_RUN + 1);
  localparam int unsigned OUT_W  = 3;

  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_EVAL,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [ADDR_W-1:0]   pos_q;
  logic                player_q;
  logic [ADDR_W-1:0]   cur_q;
  logic [CNT_W-1:0]    run_q;
  logic                done_q;
  logic                status_q;
  logic [OUT_W-1:0]    count_q;

  // Sign-extended step and the colour roles of the mover
  logic [ADDR_W-1:0] step_ext_c;
  logic [1:0]        opp_cell_c;
  logic [1:0]        own_cell_c;
  logic              off_board_c;
  logic              run_ok_c;

  always_comb begin
    step_ext_c  = {{(ADDR_W - STEP_W){step_q[STEP_W-1]}}, step_q};
    opp_cell_c  = player_q ? CELL_BLACK : CELL_WHITE;
    own_cell_c  = player_q ? CELL_WHITE : CELL_BLACK;
    off_board_c = (32'(cur_q) >= BOARD_CELLS);
    run_ok_c    = (32'(run_q) < MAX_RUN);
  end

  // Walk FSM; addresses wrap mod 128 and off-board addresses never use memory
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      pos_q    <= '0;
      player_q <= 1'b0;
      cur_q    <= '0;
      run_q    <= '0;
      done_q   <= 1'b0;
      status_q <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ld) begin
            step_q   <= bus.step_in;
            pos_q    <= bus.pos_in;
            player_q <= bus.player_in;
          end
          if (bus.enable) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          cur_q    <= pos_q + step_ext_c;
          run_q    <= '0;
          status_q <= 1'b0;
          count_q  <= '0;
          state_q  <= S_READ;
        end
        S_READ: begin
          // Address held on cur_q; memory answers during S_EVAL
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (!off_board_c && (bus.mem_data_i == opp_cell_c) && run_ok_c) begin
            run_q   <= run_q + CNT_W'(1);
            cur_q   <= cur_q + step_ext_c;
            state_q <= S_READ;
          end else begin
            // Own disc brackets only if something was passed; all else is border
            status_q <= !off_board_c && (bus.mem_data_i == own_cell_c) && (run_q != '0);
            count_q  <= OUT_W'(run_q);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr_o   = cur_q;
  assign bus.s_done_o     = done_q;
  assign bus.dir_status_o = status_q;
  assign bus.count_o      = count_q;

endmodule

// File: tb/tb_validator.sv
// Bench for the direction validator: directed walk table, hand-written
// multi-cycle sequences, and random boards checked against a walk model.
module tb_validator;

  localparam int MAX_RUN = 8;
  localparam int CELLS   = 100;

  logic clock;
  logic reset;
  validator_if bus ();

  validator #(.BOARD_CELLS(CELLS), .MAX_RUN(MAX_RUN)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read board memory
  logic [1:0] mem [128];
  always @(posedge clock) bus.mem_data_i <= mem[bus.mem_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Border ring 11, interior empty; off-board addresses hold white so any
  // illegal use by a black walk shows up as extra counted discs.
  task automatic clear_board();
    for (int i = 0; i < 128; i++) begin
      if (i >= CELLS) mem[i] = 2'b10;
      else if (i / 10 == 0 || i / 10 == 9 || i % 10 == 0 || i % 10 == 9) mem[i] = 2'b11;
      else mem[i] = 2'b00;
    end
  endtask

  // Reference walk: plain loop over the rules, latency from opponent count
  task automatic model(input int pos, input int step, input int player,
                       output int st, output int cnt, output int last);
    int cur;
    int opp;
    int own;
    opp = player ? 1 : 2;
    own = player ? 2 : 1;
    cur = ((pos + step) % 128 + 128) % 128;
    cnt = 0;
    st  = 0;
    for (int k = 0; k <= MAX_RUN; k++) begin
      last = cur;
      if (cur >= CELLS) break;
      if (int'(mem[cur]) == opp && cnt < MAX_RUN) begin
        cnt++;
        cur = ((cur + step) % 128 + 128) % 128;
      end else begin
        st = (int'(mem[cur]) == own && cnt > 0) ? 1 : 0;
        break;
      end
    end
  endtask

  // Start a walk and wait (bounded) for s_done_o; lat counts negedges after
  // the enable-sampling edge, first is mem_addr_o one cycle into the walk.
  task automatic run_walk(input int pos, input int step, input int player, input bit do_ld,
                          output int st, output int cnt, output int lat,
                          output int first, output int last, output bit ok);
    @(negedge clock);
    if (do_ld) begin
      bus.ld        = 1'b1;
      bus.pos_in    = 7'(pos);
      bus.step_in   = 5'(step);
      bus.player_in = 1'(player);
    end
    bus.enable = 1'b1;
    @(negedge clock);
    bus.ld     = 1'b0;
    bus.enable = 1'b0;
    lat   = 1;
    first = 0;
    while (bus.s_done_o !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
      if (lat == 2) first = int'(bus.mem_addr_o);
    end
    ok   = (bus.s_done_o === 1'b1);
    st   = int'(bus.dir_status_o);
    cnt  = int'(bus.count_o);
    last = int'(bus.mem_addr_o);
  endtask

  typedef struct {
    string         name;
    int            pos;
    int            step;
    int            player;
    int            ncell;
    int            caddr [4];
    logic [1:0]    cdata [4];
    int            exp_st;
    int            exp_cnt;
    int            exp_lat;
    int            exp_last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int st, cnt, lat, first, last, mst, mcnt, mlast, ndone;
    bit ok;

    bus.enable = 1'b0;
    bus.ld = 1'b0;
    bus.step_in = '0;
    bus.pos_in = '0;
    bus.player_in = 1'b0;
    clear_board();

    vecs[0] = '{"bracket2",    44,   1, 0, 3, '{45, 46, 47, 0}, '{2'b10, 2'b10, 2'b01, 2'b00}, 1, 2,  8, 47};
    vecs[1] = '{"own_adjacent",44,  -1, 0, 1, '{43, 0, 0, 0},   '{2'b01, 2'b00, 2'b00, 2'b00}, 0, 0,  4, 43};
    vecs[2] = '{"to_empty",    44, -10, 1, 2, '{34, 24, 0, 0},  '{2'b01, 2'b00, 2'b00, 2'b00}, 0, 1,  6, 24};
    vecs[3] = '{"to_border",   44,   1, 0, 4, '{45, 46, 47, 48}, '{2'b10, 2'b10, 2'b10, 2'b10}, 0, 4, 12, 49};
    vecs[4] = '{"white_down",  55,  10, 1, 3, '{65, 75, 85, 0}, '{2'b01, 2'b01, 2'b10, 2'b00}, 1, 2,  8, 85};
    vecs[5] = '{"off_high",    95,  10, 0, 0, '{0, 0, 0, 0},    '{2'b00, 2'b00, 2'b00, 2'b00}, 0, 0,  4, 105};
    vecs[6] = '{"off_wrap",     3, -10, 0, 0, '{0, 0, 0, 0},    '{2'b00, 2'b00, 2'b00, 2'b00}, 0, 0,  4, 121};
    vecs[7] = '{"own_white",   12,  -1, 1, 1, '{11, 0, 0, 0},   '{2'b10, 2'b00, 2'b00, 2'b00}, 0, 0,  4, 11};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_done",   int'(bus.s_done_o),     0);
    check("rst_status", int'(bus.dir_status_o), 0);
    check("rst_count",  int'(bus.count_o),      0);
    check("rst_addr",   int'(bus.mem_addr_o),   0);
    reset = 1'b1;

    // Directed table
    foreach (vecs[v]) begin
      clear_board();
      for (int c = 0; c < vecs[v].ncell; c++) mem[vecs[v].caddr[c]] = vecs[v].cdata[c];
      run_walk(vecs[v].pos, vecs[v].step, vecs[v].player, 1'b1, st, cnt, lat, first, last, ok);
      check({vecs[v].name, "_done"},   int'(ok), 1);
      check({vecs[v].name, "_status"}, st,   vecs[v].exp_st);
      check({vecs[v].name, "_count"},  cnt,  vecs[v].exp_cnt);
      check({vecs[v].name, "_lat"},    lat,  vecs[v].exp_lat);
      check({vecs[v].name, "_first"},  first, ((vecs[v].pos + vecs[v].step) % 128 + 128) % 128);
      check({vecs[v].name, "_last"},   last, vecs[v].exp_last);
      @(negedge clock);
      check({vecs[v].name, "_pulse"},  int'(bus.s_done_o), 0);
    end

    // Enable pulsed during S_EVAL is ignored: one done only
    clear_board();
    mem[45] = 2'b10; mem[46] = 2'b10; mem[47] = 2'b01;
    @(negedge clock);
    bus.ld = 1'b1; bus.pos_in = 7'd44; bus.step_in = 5'(1); bus.player_in = 1'b0; bus.enable = 1'b1;
    @(negedge clock);
    bus.ld = 1'b0; bus.enable = 1'b0;
    ndone = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clock);
      bus.enable = (k == 3);
      if (bus.s_done_o === 1'b1) ndone++;
    end
    check("eval_enable_ndone", ndone, 1);
    check("eval_enable_status", int'(bus.dir_status_o), 1);

    // ld outside S_IDLE ignored: next enable-only walk reuses 44/+1/black
    @(negedge clock);
    bus.enable = 1'b1;
    @(negedge clock);
    bus.enable = 1'b0;
    @(negedge clock);
    bus.ld = 1'b1; bus.pos_in = 7'd20; bus.step_in = 5'(-1); bus.player_in = 1'b1;
    @(negedge clock);
    bus.ld = 1'b0;
    repeat (12) @(negedge clock);
    run_walk(0, 0, 0, 1'b0, st, cnt, lat, first, last, ok);
    check("ld_ignored_first",  first, 45);
    check("ld_ignored_status", st, 1);
    check("ld_ignored_count",  cnt, 2);

    // Reset at cycle 3 aborts the walk with no done and cleared outputs
    @(negedge clock);
    bus.ld = 1'b1; bus.pos_in = 7'd44; bus.step_in = 5'(1); bus.player_in = 1'b0; bus.enable = 1'b1;
    @(negedge clock);
    bus.ld = 1'b0; bus.enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("rst_mid_status", int'(bus.dir_status_o), 0);
    check("rst_mid_count",  int'(bus.count_o), 0);
    check("rst_mid_addr",   int'(bus.mem_addr_o), 0);
    ndone = 0;
    repeat (15) begin
      @(negedge clock);
      if (bus.s_done_o === 1'b1) ndone++;
    end
    check("rst_mid_ndone", ndone, 0);
    run_walk(44, 1, 0, 1'b1, st, cnt, lat, first, last, ok);
    check("post_rst_status", st, 1);
    check("post_rst_count",  cnt, 2);
    check("post_rst_lat",    lat, 8);

    // ld+enable together with a new step after a +1 walk
    run_walk(44, -10, 0, 1'b1, st, cnt, lat, first, last, ok);
    check("ld_en_first", first, 34);
    check("ld_en_lat",   lat, 4);

    // Random boards against the walk model
    for (int t = 0; t < 40; t++) begin
      int pos, step, player;
      int steps [4] = '{-10, 10, -1, 1};
      clear_board();
      for (int i = 0; i < CELLS; i++)
        if (mem[i] != 2'b11) mem[i] = 2'($urandom_range(0, 2));
      for (int i = CELLS; i < 128; i++) mem[i] = 2'($urandom_range(0, 3));
      pos    = 10 * $urandom_range(1, 8) + $urandom_range(1, 8);
      step   = steps[$urandom_range(0, 3)];
      player = $urandom_range(0, 1);
      model(pos, step, player, mst, mcnt, mlast);
      run_walk(pos, step, player, 1'b1, st, cnt, lat, first, last, ok);
      check("rnd_done",   int'(ok), 1);
      check("rnd_status", st,  mst);
      check("rnd_count",  cnt, mcnt);
      check("rnd_lat",    lat, 2 * (mcnt + 1) + 2);
      check("rnd_last",   last, mlast);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/validator.md
VALIDATOR -- requirements
Module: validator

Interface
REQ-001 Parameter BOARD_CELLS, default 100, meaning number of addressable board cells (10x10 incl. border ring).
REQ-002 Parameter MAX_RUN, default 8, meaning maximum cells walked before forced abort.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  start pulse from new-move controller.
REQ-006 ld  input  1  load step_in, pos_in, player_in into internal registers.
REQ-007 step_in  input  5  signed two's-complement walk step (-10, 10, -1, 1).
REQ-008 pos_in  input  7  board address of candidate move.
REQ-009 player_in  input  1  mover colour: 0 black, 1 white.
REQ-010 mem_addr_o  output  7  board memory read address.
REQ-011 mem_data_i  input  2  cell contents: 00 empty, 01 black, 10 white, 11 border.
REQ-012 s_done_o  output  1  one-cycle completion pulse.
REQ-013 dir_status_o  output  1  1 = direction brackets at least one opponent disc.
REQ-014 count_o  output  3  number of opponent discs passed in the last walk.

Function
REQ-015 Board memory is synchronous-read: mem_data_i is valid in the cycle after mem_addr_o is presented; mem_addr_o SHALL be held stable through that cycle.
REQ-016 States: S_IDLE, S_START, S_READ, S_EVAL, S_DONE.
REQ-017 ld=1 in S_IDLE loads step_r, pos_r, player_r at that edge; ld outside S_IDLE SHALL be ignored.
REQ-018 enable=1 in S_IDLE -> S_START; enable in any other state SHALL be ignored; ld and enable in the same cycle SHALL start a walk using the newly loaded values.
REQ-019 S_START: cur_r <= pos_r + sign-extended step_r (mod 128); run counter <= 0; dir_status_o <= 0; count_o <= 0; -> S_READ.
REQ-020 S_READ: mem_addr_o = cur_r; -> S_EVAL.
REQ-021 S_EVAL, cell = opponent colour and counter < MAX_RUN: counter+1, cur_r <= cur_r + step, -> S_READ.
REQ-022 S_EVAL, cell = own colour: dir_status_o <= (counter != 0), count_o <= counter, -> S_DONE.
REQ-023 S_EVAL, cell empty or border: dir_status_o <= 0, count_o <= counter, -> S_DONE.
REQ-024 cur_r >= BOARD_CELLS, or counter = MAX_RUN with opponent cell: SHALL be treated as border (status 0), no memory value used.
REQ-025 S_DONE: s_done_o = 1 for exactly this cycle; -> S_IDLE.
REQ-026 dir_status_o and count_o SHALL be valid in the s_done_o cycle and held until the next S_START.
REQ-027 Latency: with n opponent discs before the terminating cell, s_done_o SHALL assert 2(n+1)+2 cycles after the edge sampling enable.
REQ-028 mem_addr_o SHALL equal cur_r in all states (no X output).

Reset
REQ-029 reset=0 at an edge: state <= S_IDLE, s_done_o, dir_status_o, count_o, step_r, pos_r, player_r, cur_r <= 0, regardless of state.
REQ-030 Reset mid-walk SHALL abort with no s_done_o pulse; first post-reset enable starts a clean walk.

Verification
REQ-031 Black, pos 44, step +1, cells 45=10, 46=10, 47=01 -> s_done_o at cycle 8, dir_status_o=1, count_o=2.
REQ-032 Black, pos 44, step -1, cell 43=01 -> s_done_o at cycle 4, dir_status_o=0, count_o=0.
REQ-033 White, pos 44, step -10, 34=01, 24=00 -> dir_status_o=0, count_o=1, done at cycle 6.
REQ-034 Black, pos 44, step +1, 45..48=10, 49=11 -> dir_status_o=0, count_o=4, no access beyond 49.
REQ-035 enable pulsed during S_EVAL of a walk -> ignored, single s_done_o; reset=0 at cycle 3 -> S_IDLE, no s_done_o, outputs 0.
REQ-036 ld+enable same cycle with step -10 after prior step +1 -> first mem_addr_o = pos-10.
